// File: rtl/slot_alloc_if.sv
// Allocation/free handshake bundle for slot_alloc.
// The requester owns i_* and the allocator owns o_*.
interface slot_alloc_if #(
    parameter int N = 8
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          i_alloc_vld;
    logic          o_alloc_rdy;
    logic [IW-1:0] o_alloc_id;
    logic [N-1:0]  o_alloc_oh;
    logic          i_free_vld;
    logic [IW-1:0] i_free_id;
    logic [N-1:0]  o_busy;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_err;

    modport master (
        output i_alloc_vld, i_free_vld, i_free_id,
        input  o_alloc_rdy, o_alloc_id, o_alloc_oh,
        input  o_busy, o_count, o_full, o_empty, o_err
    );

    modport slave (
        input  i_alloc_vld, i_free_vld, i_free_id,
        output o_alloc_rdy, o_alloc_id, o_alloc_oh,
        output o_busy, o_count, o_full, o_empty, o_err
    );
endinterface

// File: rtl/slot_alloc.sv
// Free-slot allocator: grants the first free slot from a busy vector,
// returns freed slots to the pool and flags illegal frees.
module lzd #(
    parameter int N           = 8,
    parameter bit FROM_LSB    = 1'b1,
    parameter bit DETECT_ZERO = 1'b1
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] oh
);
    logic [N-1:0] v;
    logic         found;
    int           idx;

    always_comb begin
        v     = DETECT_ZERO ? ~vec : vec;
        oh    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = FROM_LSB ? i : N - 1 - i;
            if (!found && v[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
    end
endmodule

module slot_alloc #(
    parameter int N        = 8,
    parameter bit FROM_LSB = 1'b1
) (
    input logic         clk,
    input logic         rst,
    slot_alloc_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  busy;
    logic [N-1:0]  pick;
    logic [CW-1:0] count;
    logic          err;
    logic [IW-1:0] pick_id;
    logic          full;
    logic          alloc_fire;
    logic          id_ok;
    logic [N-1:0]  free_sel;
    logic          free_fire;
    logic          free_bad;
    logic [N-1:0]  set_mask;
    logic [N-1:0]  clr_mask;

    lzd #(
        .N          (N),
        .FROM_LSB   (FROM_LSB),
        .DETECT_ZERO(1'b1)
    ) u_lzd (
        .vec(busy),
        .oh (pick)
    );

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) pick_id = pick_id | IW'(i);
        end
    end

    assign full       = (count == CW'(N));
    assign alloc_fire = bus.i_alloc_vld & ~full;

    // Out-of-range ids shift the select bit off the top, so free_sel is 0.
    assign id_ok     = ({1'b0, bus.i_free_id} < (IW + 1)'(N));
    assign free_sel  = {{(N - 1){1'b0}}, 1'b1} << bus.i_free_id;
    assign free_fire = bus.i_free_vld & id_ok & (|(busy & free_sel));
    assign free_bad  = bus.i_free_vld & ~free_fire;

    assign set_mask = alloc_fire ? pick : '0;
    assign clr_mask = free_fire ? free_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            busy  <= (busy | set_mask) & ~clr_mask;
            count <= count + CW'(alloc_fire) - CW'(free_fire);
            if (free_bad) err <= 1'b1;
        end
    end

    assign bus.o_alloc_rdy = ~full;
    assign bus.o_alloc_id  = pick_id;
    assign bus.o_alloc_oh  = pick;
    assign bus.o_busy      = busy;
    assign bus.o_count     = count;
    assign bus.o_full      = full;
    assign bus.o_empty     = (count == '0);
    assign bus.o_err       = err;

    count_matches_busy: assert property (
        @(posedge clk) disable iff (rst)
        count == CW'($countones(busy))
    );
endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: directed vector table on N=4, FROM_LSB=0 reset
// sequence, and randomized traffic on N=6 against a slot-array model.
module tb_slot_alloc;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    slot_alloc_if #(.N(4)) ifa ();
    slot_alloc_if #(.N(4)) ifb ();
    slot_alloc_if #(.N(6)) ifc ();

    slot_alloc #(.N(4), .FROM_LSB(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    slot_alloc #(.N(4), .FROM_LSB(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
    slot_alloc #(.N(6), .FROM_LSB(1'b1)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       alloc;
        bit       fv;
        int       fid;
        bit       rdy;
        int       id;
        bit [3:0] busy;
        int       cnt;
        bit       err;
    } vec_t;

    vec_t tbl[20];

    // model state for the random run
    bit       m[6];
    bit       merr;
    bit       a, fv, exp_rdy, legal;
    int       fid, gid;
    bit [5:0] eb, eoh6;
    int       ecnt;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.i_alloc_vld = 0; ifa.i_free_vld = 0; ifa.i_free_id = '0;
        ifb.i_alloc_vld = 0; ifb.i_free_vld = 0; ifb.i_free_id = '0;
        ifc.i_alloc_vld = 0; ifc.i_free_vld = 0; ifc.i_free_id = '0;

        //          alloc fv fid rdy id busy     cnt err
        tbl[0]  = '{1, 0, 0, 1, 0, 4'b0001, 1, 0};
        tbl[1]  = '{1, 0, 0, 1, 1, 4'b0011, 2, 0};
        tbl[2]  = '{1, 0, 0, 1, 2, 4'b0111, 3, 0};
        tbl[3]  = '{1, 0, 0, 1, 3, 4'b1111, 4, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 4'b1111, 4, 0};
        tbl[5]  = '{0, 1, 2, 0, 0, 4'b1011, 3, 0};
        tbl[6]  = '{0, 1, 0, 1, 2, 4'b1010, 2, 0};
        tbl[7]  = '{1, 0, 0, 1, 0, 4'b1011, 3, 0};
        tbl[8]  = '{1, 0, 0, 1, 2, 4'b1111, 4, 0};
        tbl[9]  = '{1, 1, 3, 0, 0, 4'b0111, 3, 0};
        tbl[10] = '{1, 0, 0, 1, 3, 4'b1111, 4, 0};
        tbl[11] = '{0, 1, 3, 0, 0, 4'b0111, 3, 0};
        tbl[12] = '{0, 1, 2, 1, 3, 4'b0011, 2, 0};
        tbl[13] = '{1, 1, 0, 1, 2, 4'b0110, 2, 0};
        tbl[14] = '{0, 1, 1, 1, 0, 4'b0100, 1, 0};
        tbl[15] = '{1, 0, 0, 1, 0, 4'b0101, 2, 0};
        tbl[16] = '{0, 1, 2, 1, 1, 4'b0001, 1, 0};
        tbl[17] = '{0, 1, 1, 1, 1, 4'b0001, 1, 1};
        tbl[18] = '{1, 0, 0, 1, 1, 4'b0011, 2, 1};
        tbl[19] = '{0, 0, 0, 1, 2, 4'b0011, 2, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        chk("reset_busy",  ifa.o_busy, 4'b0000);
        chk("reset_count", ifa.o_count, 0);
        chk("reset_full",  ifa.o_full, 0);
        chk("reset_empty", ifa.o_empty, 1);
        chk("reset_rdy",   ifa.o_alloc_rdy, 1);
        chk("reset_oh",    ifa.o_alloc_oh, 4'b0001);
        chk("reset_err",   ifa.o_err, 0);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ifa.i_alloc_vld = tbl[k].alloc;
            ifa.i_free_vld  = tbl[k].fv;
            ifa.i_free_id   = 2'(tbl[k].fid);
            #1;
            chk($sformatf("v%0d_rdy", k), ifa.o_alloc_rdy, tbl[k].rdy);
            if (tbl[k].rdy) chk($sformatf("v%0d_id", k), ifa.o_alloc_id, tbl[k].id);
            chk($sformatf("v%0d_oh", k), ifa.o_alloc_oh,
                tbl[k].rdy ? (32'd1 << tbl[k].id) : 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy", k),  ifa.o_busy, tbl[k].busy);
            chk($sformatf("v%0d_count", k), ifa.o_count, tbl[k].cnt);
            chk($sformatf("v%0d_full", k),  ifa.o_full, tbl[k].cnt == 4);
            chk($sformatf("v%0d_empty", k), ifa.o_empty, tbl[k].cnt == 0);
            chk($sformatf("v%0d_err", k),   ifa.o_err, tbl[k].err);
        end

        // sticky error is cleared only by reset
        @(negedge clk);
        ifa.i_alloc_vld = 0; ifa.i_free_vld = 0;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("a_rst_err",  ifa.o_err, 0);
        chk("a_rst_busy", ifa.o_busy, 4'b0000);

        // FROM_LSB=0: grants 3 then 2, then reset with alloc held high
        @(negedge clk);
        ifb.i_alloc_vld = 1;
        #1;
        chk("b_g0_id", ifb.o_alloc_id, 3);
        chk("b_g0_oh", ifb.o_alloc_oh, 4'b1000);
        @(negedge clk);
        #1;
        chk("b_g1_id",   ifb.o_alloc_id, 2);
        chk("b_g1_busy", ifb.o_busy, 4'b1000);
        @(negedge clk);
        ifb.i_alloc_vld = 0;
        ifb.i_free_vld  = 1;
        ifb.i_free_id   = 2'd0;
        #1;
        chk("b_busy2", ifb.o_busy, 4'b1100);
        @(negedge clk);
        ifb.i_free_vld  = 0;
        ifb.i_alloc_vld = 1;
        rst_b = 1'b1;
        #1;
        chk("b_err_set", ifb.o_err, 1);
        @(negedge clk);
        rst_b = 1'b0;
        ifb.i_alloc_vld = 0;
        #1;
        chk("b_rst_busy",  ifb.o_busy, 4'b0000);
        chk("b_rst_count", ifb.o_count, 0);
        chk("b_rst_err",   ifb.o_err, 0);
        chk("b_rst_id",    ifb.o_alloc_id, 3);

        // randomized traffic on N=6 with out-of-range free ids
        for (int i = 0; i < 6; i++) m[i] = 0;
        merr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            a   = ($urandom_range(0, 99) < 55);
            fv  = ($urandom_range(0, 99) < 45);
            fid = $urandom_range(0, 7);
            ifc.i_alloc_vld = a;
            ifc.i_free_vld  = fv;
            ifc.i_free_id   = 3'(fid);
            rst_c = ($urandom_range(0, 99) < 2);
            exp_rdy = 0;
            gid = 0;
            for (int i = 5; i >= 0; i--) begin
                if (!m[i]) begin
                    exp_rdy = 1;
                    gid = i;
                end
            end
            #1;
            chk("r_rdy", ifc.o_alloc_rdy, exp_rdy);
            if (exp_rdy) chk("r_id", ifc.o_alloc_id, gid);
            eoh6 = exp_rdy ? 6'(1 << gid) : 6'b0;
            chk("r_oh", ifc.o_alloc_oh, eoh6);
            legal = fv && fid < 6 && m[fid % 6];
            @(posedge clk);
            if (rst_c) begin
                for (int i = 0; i < 6; i++) m[i] = 0;
                merr = 0;
            end else begin
                if (a && exp_rdy) m[gid] = 1;
                if (legal) m[fid] = 0;
                else if (fv) merr = 1;
            end
            #1;
            ecnt = 0;
            for (int i = 0; i < 6; i++) begin
                eb[i] = m[i];
                ecnt += m[i];
            end
            chk("r_busy",  ifc.o_busy, eb);
            chk("r_count", ifc.o_count, ecnt);
            chk("r_full",  ifc.o_full, ecnt == 6);
            chk("r_empty", ifc.o_empty, ecnt == 0);
            chk("r_err",   ifc.o_err, merr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slot_alloc.md
# slot_alloc

Tracks occupancy of `N` tag/slot entries and hands out the lowest-indexed free slot on request. Freed slots are returned to the pool for reuse. It sits directly upstream of consumers that need a unique tag, such as a miss queue or ROB tag pool. Internally, a first-zero leading-zero detector (`lzd`, `DETECT_ZERO=1`) runs over the registered busy vector and produces a one-hot free-slot pick; this block encodes that pick, applies it, and keeps the busy, count and error state.

## Interface
- `N`, 8: number of slots; N ≥ 2.
- `FROM_LSB`, 1: 1 = pick the lowest free index; 0 = pick the highest free index. Passed to `lzd`.
- `IW`, `$clog2(N)`: slot ID width (derived, not overridden).
- `CW`, `$clog2(N+1)`: count width (derived).

Ports:
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `i_alloc_vld` in, 1: allocation request.
- `o_alloc_rdy` out, 1: a free slot exists (`!o_full`).
- `o_alloc_id` out, IW: binary ID of the slot granted this cycle; valid when `o_alloc_rdy`.
- `o_alloc_oh` out, N: one-hot form of `o_alloc_id`; all zero when full.
- `i_free_vld` in, 1: free request.
- `i_free_id` in, IW: slot to free.
- `o_busy` out, N: registered occupancy vector.
- `o_count` out, CW: number of busy slots.
- `o_full` out, 1: `o_count == N`.
- `o_empty` out, 1: `o_count == 0`.
- `o_err` out, 1: sticky error flag, set by an illegal free.

## Operation
- Reset (`rst`=1 at the edge):
  - `busy` = 0 and `count` = 0.
  - `err` = 0.
  - Resulting outputs: `o_full`=0, `o_empty`=1, `o_alloc_rdy`=1, `o_alloc_oh`=1 at slot 0 (FROM_LSB=1).
- `o_alloc_oh` is `lzd(busy)`, a purely combinational function of registered `busy`. `o_alloc_id` is its one-hot-to-binary encoding.
- Grant:
  - Condition: `alloc_fire = i_alloc_vld & o_alloc_rdy`.
  - On the edge after a grant, `busy |= o_alloc_oh`.
  - `i_alloc_vld` while full is ignored: no state change and no error.
- Free:
  - Condition: `free_fire = i_free_vld & (i_free_id < N) & busy[i_free_id]`.
  - On the edge after a free, `busy[i_free_id]` is cleared.
- Illegal free:
  - Cases: `i_free_vld` with `i_free_id ≥ N`, or with the slot already free.
  - Effect: ignored (no busy/count change) and `err` is set.
  - `err` clears only on `rst`.
- Count update: `count_next = count + alloc_fire − free_fire`. Both fire in the same cycle → count unchanged.
- Simultaneous alloc and free:
  - Both apply in the same edge.
  - The freed slot is not visible to the allocator until the next cycle; no same-cycle bypass.
  - A slot is never granted and freed in the same cycle, because the grant targets a slot whose busy bit is 0 and a legal free targets a slot whose busy bit is 1.
- Full boundary: at `count == N`, a same-cycle free leaves the block not full next cycle. The request in the full cycle is not granted.
- Invariant (assert in RTL): `count == popcount(busy)`.

## Timing
- Grant latency: 0 cycles. `o_alloc_rdy`, `o_alloc_id` and `o_alloc_oh` are valid in the same cycle as the request. They depend only on registers, with no combinational path from `i_*`.
- State latency: `o_busy`, `o_count`, `o_full`, `o_empty` and `o_err` reflect an alloc or free one edge later.
- Back-to-back: allocation every cycle is supported. Consecutive grants return successive free slots: 0, 1, 2, … when FROM_LSB=1.
- Reset mid-operation: all state returns to reset values on that edge, regardless of same-cycle alloc or free. Any grant shown during the reset cycle is discarded.
- Critical path: `busy` reg → lzd → encoder → `o_alloc_id`. No pipelining.

## Test plan
- Reset then fill, N=4, FROM_LSB=1:
  - Stimulus: hold `i_alloc_vld` for 5 cycles.
  - Required: IDs granted are 0, 1, 2, 3. The 5th cycle has `o_alloc_rdy`=0. Then `o_busy`=4'b1111, `o_count`=4, `o_full`=1.
- Free and reuse:
  - Stimulus: from full, free ID 2, then free ID 0, then alloc.
  - Required: the alloc grants ID 0. The next alloc grants ID 2. `o_count` goes 4→3→2→3→4.
- Simultaneous alloc and free:
  - Stimulus: `busy`=4'b0011; alloc plus free ID 0 in one cycle.
  - Required: grant ID 2; next `busy`=4'b0110; `o_count` stays 2.
- Full plus free in the same cycle:
  - Stimulus: `busy`=4'b1111; `i_alloc_vld` plus free ID 3.
  - Required: no grant that cycle. Next cycle `o_alloc_rdy`=1 with ID 3.
- Illegal free:
  - Stimulus: free ID 1 while `busy`=4'b0001.
  - Required: `o_busy` unchanged; `o_err`=1 the next cycle and it stays 1 until `rst`.
- FROM_LSB=0 and reset mid-fill:
  - Stimulus: FROM_LSB=0, N=4; allocate twice, then assert `rst` with `i_alloc_vld` high.
  - Required: grants 3 then 2. After the reset edge, `o_busy`=0, `o_count`=0, `o_err`=0.
